sexa_display_sched: RTL and testbench
=====================================

# sexa_display_sched

Time-of-day controller that keeps seconds, minutes and hours counters and time-multiplexes one shared 6-bit sexagesimal-to-BCD converter across the six display digits. It sits between the 1 Hz tick source and set inputs on one side, and the shared converter and the multiplexed 6-digit display driver on the other. The converter is external and purely combinational: it takes a value 0..63 and returns a tens digit on bits [6:4] and a units digit on bits [3:0].

## Interface
- SCAN_DIV, default 4: clock cycles per display slot. Legal range is 1..255.
- clk  in  1  single clock; all registers are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz advance strobe.
- set_req  in  1  request to write one field; held high until set_ack.
- set_field  in  2  field to write: 0=sec, 1=min, 2=hr; 3 is illegal.
- set_value  in  6  new field value.
- set_ack  out  1  one-cycle acknowledge of set_req.
- set_err  out  1  valid with set_ack; high means the write was rejected.
- sec  out  6  seconds, 0..59.
- min  out  6  minutes, 0..59.
- hr  out  6  hours, 0..23.
- conv_in  out  6  operand to the shared converter.
- conv_out  in  7  converter result: [6:4] tens, [3:0] units.
- digit_sel  out  6  one-hot active digit. Bit 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens, 4 = hr units, 5 = hr tens.
- digit_bcd  out  4  BCD value for the digit selected by digit_sel.

## Operation
- Reset values:
  - sec, min, hr: 0.
  - set_ack, set_err: 0.
  - digit_sel: 6'b000000 (display blank).
  - digit_bcd: 0.
  - slot: 0. div: 0. tick_pend: 0.
- Timekeeping, applied on an effective tick (tick, or tick_pend):
  - sec increments.
  - When sec is 59, sec goes to 0 and min increments.
  - When min wraps 59 to 0, hr increments.
  - When hr is 23 and wraps, hr goes to 0.
  - The full carry chain completes in one cycle.
- Set handshake:
  - set_req is sampled when set_ack is low. In the sampled cycle the block writes the field and drives set_ack=1 for exactly that next cycle.
  - set_req high during the ack cycle is ignored. The requester drops set_req after seeing set_ack.
  - Legal write: set_field is 0..2 and set_value is below the modulus (60/60/24). The field is written and set_err=0.
  - Illegal write: no field changes and set_err=1.
- Tick/set collision:
  - A set is accepted on the same edge as a tick. The set takes priority.
  - The tick is held in tick_pend and applied on the next edge, after the written value.
  - A tick arriving while tick_pend=1 and no set is accepted: the pending tick and the new tick together advance the count by 2 s.
- Display scanner:
  - div counts 0..SCAN_DIV-1. slot counts 0..5 and wraps to 0.
  - conv_in is combinational from slot: sec for slots 0–1, min for slots 2–3, hr for slots 4–5.
  - On the edge where div==SCAN_DIV-1:
    - digit_bcd is loaded with conv_out[3:0] for even slots and {1'b0,conv_out[6:4]} for odd slots.
    - digit_sel is loaded with one-hot(slot).
    - slot advances and div returns to 0.
- The scanner runs independently of set and tick activity. A field changed mid-slot is shown with its value at the end of that slot.

## Timing
- sec/min/hr are updated on the edge that samples tick high and are visible in the next cycle.
- set_ack and the field update occur on the same edge, 1 cycle after set_req is sampled.
- Display latency: digit k is latched at the end of slot k and is held for SCAN_DIV cycles, while slot k+1 is being converted.
- digit_sel first becomes non-zero SCAN_DIV cycles after rst is released. A full refresh takes 6*SCAN_DIV cycles.
- rst asserted mid-operation clears every register immediately (asynchronously), including tick_pend and any in-flight ack. A set_req still held high after rst is released is treated as a new request.

## Test plan
- Reset release, SCAN_DIV=4: digit_sel=0 for cycles 0–3. At cycle 4, digit_sel=000001 and digit_bcd=0. digit_sel then rotates through all 6 bits every 24 cycles.
- Set hr=23, min=59, sec=59, then one tick -> sec=min=hr=0 on the next cycle, with no intermediate values.
- set_field=0, set_value=60 -> set_ack=1 with set_err=1 and sec unchanged. set_field=3 -> rejected in the same way.
- Set sec=37 on the same cycle as a tick -> sec=37 after the ack edge, then 38 one cycle later.
- With time 14:07:52, SCAN_DIV=1 -> digit_bcd cycles 2,5,7,0,4,1 in slots 0..5, with conv_in=52,52,7,7,14,14.
- Assert rst mid-handshake while set_ack=1 and tick_pend=1 -> all outputs return to their reset values immediately. No pending tick is applied after release.

Source files
------------

// File: rtl/sexa_display_sched.sv
// Time-of-day keeper (sec/min/hr) with set handshake and a 6-digit display
// scanner that time-shares one external sexagesimal-to-BCD converter.
module sexa_display_sched #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       set_req,
   input  logic [1:0] set_field,
   input  logic [5:0] set_value,
   output logic       set_ack,
   output logic       set_err,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [5:0] hr,
   output logic [5:0] conv_in,
   input  logic [6:0] conv_out,
   output logic [5:0] digit_sel,
   output logic [3:0] digit_bcd
);

   localparam int unsigned DIV_W  = 8;
   localparam int unsigned SLOT_W = 3;
   localparam int unsigned TIME_W = 18;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = 3'd5;

   logic [5:0]        sec_q, sec_d, min_q, min_d, hr_q, hr_d;
   logic              set_ack_q, set_ack_d, set_err_q, set_err_d;
   logic              tick_pend_q, tick_pend_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [5:0]        digit_sel_q, digit_sel_d;
   logic [3:0]        digit_bcd_q, digit_bcd_d;
   logic [TIME_W-1:0] time_cur, time_nxt;
   logic              set_take;

   // One-second advance with the full sec->min->hr carry chain; packed {hr,min,sec}.
   function automatic logic [TIME_W-1:0] inc_time(input logic [TIME_W-1:0] t);
      logic [5:0] s, m, h;
      {h, m, s} = t;
      if (s == 6'd59) begin
         s = 6'd0;
         if (m == 6'd59) begin
            m = 6'd0;
            h = (h == 6'd23) ? 6'd0 : h + 6'd1;
         end else begin
            m = m + 6'd1;
         end
      end else begin
         s = s + 6'd1;
      end
      return {h, m, s};
   endfunction

   // Timekeeping and set handshake; an accepted set defers any tick by one edge.
   always_comb begin
      time_cur    = {hr_q, min_q, sec_q};
      time_nxt    = time_cur;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      set_ack_d   = 1'b0;
      set_err_d   = 1'b0;
      tick_pend_d = 1'b0;
      set_take    = set_req && !set_ack_q;
      if (set_take) begin
         set_ack_d   = 1'b1;
         tick_pend_d = tick || tick_pend_q;
         case (set_field)
            2'd0:    if (set_value < 6'd60) sec_d = set_value; else set_err_d = 1'b1;
            2'd1:    if (set_value < 6'd60) min_d = set_value; else set_err_d = 1'b1;
            2'd2:    if (set_value < 6'd24) hr_d  = set_value; else set_err_d = 1'b1;
            default: set_err_d = 1'b1;
         endcase
      end else begin
         if (tick && tick_pend_q) begin
            time_nxt = inc_time(inc_time(time_cur));
         end else if (tick || tick_pend_q) begin
            time_nxt = inc_time(time_cur);
         end
         {hr_d, min_d, sec_d} = time_nxt;
      end
   end

   // Converter operand follows the slot currently being converted.
   always_comb begin
      case (slot_q)
         3'd0, 3'd1: conv_in = sec_q;
         3'd2, 3'd3: conv_in = min_q;
         default:    conv_in = hr_q;
      endcase
   end

   // Scanner: latch the converted digit at the end of each slot.
   always_comb begin
      div_d       = div_q + DIV_W'(1);
      slot_d      = slot_q;
      digit_sel_d = digit_sel_q;
      digit_bcd_d = digit_bcd_q;
      if (div_q == DIV_LAST) begin
         div_d       = '0;
         slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
         digit_sel_d = 6'(1) << slot_q;
         digit_bcd_d = slot_q[0] ? {1'b0, conv_out[6:4]} : conv_out[3:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         set_ack_q   <= 1'b0;
         set_err_q   <= 1'b0;
         tick_pend_q <= 1'b0;
         div_q       <= '0;
         slot_q      <= '0;
         digit_sel_q <= '0;
         digit_bcd_q <= '0;
      end else begin
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         set_ack_q   <= set_ack_d;
         set_err_q   <= set_err_d;
         tick_pend_q <= tick_pend_d;
         div_q       <= div_d;
         slot_q      <= slot_d;
         digit_sel_q <= digit_sel_d;
         digit_bcd_q <= digit_bcd_d;
      end
   end

   assign sec       = sec_q;
   assign min       = min_q;
   assign hr        = hr_q;
   assign set_ack   = set_ack_q;
   assign set_err   = set_err_q;
   assign digit_sel = digit_sel_q;
   assign digit_bcd = digit_bcd_q;

endmodule

// File: tb/tb_sexa_display_sched.sv
// Directed bench for sexa_display_sched: two instances (SCAN_DIV=4 and 1) on shared stimulus.
module tb_sexa_display_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       set_req;
   logic [1:0] set_field;
   logic [5:0] set_value;

   logic       set_ack, set_err;
   logic [5:0] sec, min, hr, conv_in, digit_sel;
   logic [6:0] conv_out;
   logic [3:0] digit_bcd;

   logic       set_ack1, set_err1;
   logic [5:0] sec1, min1, hr1, conv_in1, digit_sel1;
   logic [6:0] conv_out1;
   logic [3:0] digit_bcd1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Reference model of the external combinational converter.
   assign conv_out  = {3'(conv_in / 6'd10),  4'(conv_in % 6'd10)};
   assign conv_out1 = {3'(conv_in1 / 6'd10), 4'(conv_in1 % 6'd10)};

   sexa_display_sched #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .tick(tick), .set_req(set_req), .set_field(set_field),
      .set_value(set_value), .set_ack(set_ack), .set_err(set_err), .sec(sec), .min(min),
      .hr(hr), .conv_in(conv_in), .conv_out(conv_out), .digit_sel(digit_sel),
      .digit_bcd(digit_bcd));

   sexa_display_sched #(.SCAN_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .set_req(set_req), .set_field(set_field),
      .set_value(set_value), .set_ack(set_ack1), .set_err(set_err1), .sec(sec1), .min(min1),
      .hr(hr1), .conv_in(conv_in1), .conv_out(conv_out1), .digit_sel(digit_sel1),
      .digit_bcd(digit_bcd1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one set request (optionally with a coincident tick) and check its ack edge.
   task automatic do_set(input logic [1:0] f, input logic [5:0] v, input logic with_tick,
                         input logic exp_err, input string name);
      set_req   = 1'b1;
      set_field = f;
      set_value = v;
      tick      = with_tick;
      step();
      checks++;
      if (set_ack !== 1'b1 || set_err !== exp_err) begin
         errors++;
         $display("FAIL %s ack/err: got %b/%b want 1/%b", name, set_ack, set_err, exp_err);
      end
      set_req = 1'b0;
      tick    = 1'b0;
   endtask

   task automatic check_time(input string name, input logic [5:0] eh, input logic [5:0] em,
                             input logic [5:0] es);
      checks++;
      if (hr !== eh || min !== em || sec !== es) begin
         errors++;
         $display("FAIL %s time: got %0d:%0d:%0d want %0d:%0d:%0d", name, hr, min, sec,
                  eh, em, es);
      end
   endtask

   task automatic test_reset();
      logic [5:0] exp_sel;
      rst = 1'b1; tick = 1'b0; set_req = 1'b0; set_field = '0; set_value = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({sec, min, hr, set_ack, set_err, digit_sel, digit_bcd, conv_in} !== '0) begin
         errors++;
         $display("FAIL reset_values: sec=%0d min=%0d hr=%0d ack=%b err=%b sel=%b bcd=%0d cin=%0d",
                  sec, min, hr, set_ack, set_err, digit_sel, digit_bcd, conv_in);
      end
      rst = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         step();
         checks++;
         if (digit_sel !== 6'b0) begin
            errors++;
            $display("FAIL blank_cycle%0d: sel=%b want 000000", c, digit_sel);
         end
      end
      step();
      checks++;
      if (digit_sel !== 6'b000001 || digit_bcd !== 4'd0) begin
         errors++;
         $display("FAIL first_digit: sel=%b bcd=%0d want 000001/0", digit_sel, digit_bcd);
      end
      exp_sel = 6'b000001;
      for (int s = 1; s <= 6; s++) begin
         repeat (4) step();
         exp_sel = {exp_sel[4:0], exp_sel[5]};
         checks++;
         if (digit_sel !== exp_sel) begin
            errors++;
            $display("FAIL rotate%0d: sel=%b want %b", s, digit_sel, exp_sel);
         end
      end
   endtask

   task automatic test_carry();
      do_set(2'd2, 6'd23, 1'b0, 1'b0, "set_hr23");  step();
      do_set(2'd1, 6'd59, 1'b0, 1'b0, "set_min59"); step();
      do_set(2'd0, 6'd59, 1'b0, 1'b0, "set_sec59"); step();
      check_time("pre_carry", 6'd23, 6'd59, 6'd59);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check_time("full_carry", 6'd0, 6'd0, 6'd0);
   endtask

   task automatic test_illegal();
      do_set(2'd0, 6'd5, 1'b0, 1'b0, "set_sec5");
      check_time("sec5", 6'd0, 6'd0, 6'd5);
      step();
      do_set(2'd0, 6'd60, 1'b0, 1'b1, "sec60");
      check_time("sec60_unchanged", 6'd0, 6'd0, 6'd5);
      step();
      do_set(2'd3, 6'd5, 1'b0, 1'b1, "field3");
      check_time("field3_unchanged", 6'd0, 6'd0, 6'd5);
      step();
      do_set(2'd2, 6'd24, 1'b0, 1'b1, "hr24");
      check_time("hr24_unchanged", 6'd0, 6'd0, 6'd5);
      step();
      checks++;
      if (set_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_one_cycle: ack=%b want 0", set_ack);
      end
   endtask

   task automatic test_collision();
      do_set(2'd0, 6'd37, 1'b1, 1'b0, "sec37_tick");
      check_time("set_wins", 6'd0, 6'd0, 6'd37);
      step();
      check_time("pend_applied", 6'd0, 6'd0, 6'd38);
      step();
      check_time("pend_cleared", 6'd0, 6'd0, 6'd38);
   endtask

   task automatic test_back_to_back();
      do_set(2'd1, 6'd59, 1'b0, 1'b0, "set_min59b"); step();
      do_set(2'd0, 6'd58, 1'b1, 1'b0, "sec58_tick");
      check_time("sec58", 6'd0, 6'd59, 6'd58);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check_time("double_advance", 6'd1, 6'd0, 6'd0);
      step();
      check_time("after_double", 6'd1, 6'd0, 6'd0);
   endtask

   task automatic test_display();
      int bcd_tab[6]  = '{2, 5, 7, 0, 4, 1};
      int conv_tab[6] = '{52, 52, 7, 7, 14, 14};
      int k, prev;
      do_set(2'd2, 6'd14, 1'b0, 1'b0, "set_hr14"); step();
      do_set(2'd1, 6'd7,  1'b0, 1'b0, "set_min7"); step();
      do_set(2'd0, 6'd52, 1'b0, 1'b0, "set_sec52"); step();
      prev = -1;
      for (int n = 0; n < 12; n++) begin
         step();
         k = -1;
         for (int b = 0; b < 6; b++) if (digit_sel1 == (6'(1) << b)) k = b;
         checks++;
         if (k < 0 || (prev >= 0 && k != (prev + 1) % 6)) begin
            errors++;
            $display("FAIL scan_sel n=%0d: sel=%b prev_slot=%0d", n, digit_sel1, prev);
         end else begin
            checks++;
            if (digit_bcd1 !== 4'(bcd_tab[k]) || conv_in1 !== 6'(conv_tab[(k + 1) % 6])) begin
               errors++;
               $display("FAIL scan_digit%0d: bcd=%0d cin=%0d want %0d/%0d", k, digit_bcd1,
                        conv_in1, bcd_tab[k], conv_tab[(k + 1) % 6]);
            end
         end
         prev = k;
      end
   endtask

   task automatic test_reset_mid();
      set_req = 1'b1; set_field = 2'd0; set_value = 6'd20; tick = 1'b1;
      step();
      checks++;
      if (set_ack !== 1'b1 || sec !== 6'd20) begin
         errors++;
         $display("FAIL mid_setup: ack=%b sec=%0d want 1/20", set_ack, sec);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({sec, min, hr, set_ack, set_err, digit_sel, digit_bcd} !== '0) begin
         errors++;
         $display("FAIL async_reset: sec=%0d min=%0d hr=%0d ack=%b sel=%b bcd=%0d",
                  sec, min, hr, set_ack, digit_sel, digit_bcd);
      end
      set_req = 1'b0; tick = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      check_time("no_pend_after_rst", 6'd0, 6'd0, 6'd0);
      checks++;
      if (set_ack !== 1'b0 || digit_sel !== 6'b0) begin
         errors++;
         $display("FAIL post_rst: ack=%b sel=%b want 0/000000", set_ack, digit_sel);
      end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_illegal();
      test_collision();
      test_back_to_back();
      test_display();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
